// File: rtl/axis_trim_pkg.sv
// axis_trim_pkg: FSM states and default counter width for axis_pkt_len_trim.
package axis_trim_pkg;
  typedef enum logic [1:0] {S_IDLE, S_PASS, S_DISCARD} trim_state_e;
  localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/axi_stream_inf.sv
// axi_stream_inf: AXI-stream bundle with tdata/tkeep/tuser/tlast/tvalid/tready.
interface axi_stream_inf #(
  parameter int DSIZE = 32,
  parameter int KSIZE = DSIZE / 8,
  parameter int USIZE = 1
);
  logic [DSIZE-1:0] axis_tdata;
  logic [KSIZE-1:0] axis_tkeep;
  logic [USIZE-1:0] axis_tuser;
  logic             axis_tlast;
  logic             axis_tvalid;
  logic             axis_tready;
  modport master (output axis_tdata, axis_tkeep, axis_tuser, axis_tlast, axis_tvalid, input axis_tready);
  modport slaver (input axis_tdata, axis_tkeep, axis_tuser, axis_tlast, axis_tvalid, output axis_tready);
endinterface

// File: rtl/axis_trim_skid_buf.sv
// axis_trim_skid_buf: 2-entry registered output slice, full throughput, outputs held under back-pressure.
module axis_trim_skid_buf #(
  parameter int W          = 8,
  parameter int SKID_DEPTH = 2
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic [W-1:0] src_data,
  input  logic         src_valid,
  output logic         src_ready,
  output logic [W-1:0] dst_data,
  output logic         dst_valid,
  input  logic         dst_ready
);
  if (SKID_DEPTH != 2) begin : g_bad_depth
    $error("axis_trim_skid_buf: SKID_DEPTH must be 2");
  end
  logic [W-1:0] sk_data;
  logic         sk_valid, load, push, sk_next;
  always_comb begin
    push    = src_valid && src_ready;
    load    = !dst_valid || dst_ready;
    sk_next = !load && (sk_valid || push);
  end
  // src_ready is registered as "skid slot empty"; it stays low while in reset
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      dst_valid <= 1'b0;
      dst_data  <= '0;
      sk_valid  <= 1'b0;
      sk_data   <= '0;
      src_ready <= 1'b0;
    end else begin
      src_ready <= !sk_next;
      sk_valid  <= sk_next;
      if (load) begin
        dst_valid <= sk_valid || push;
        dst_data  <= sk_valid ? sk_data : src_data;
      end else if (push) begin
        sk_data <= src_data;
      end
    end
  end
endmodule

// File: rtl/axis_pkt_len_trim.sv
// axis_pkt_len_trim: per-packet beat-length limiter on an AXI stream with a registered output slice.
// Define AXIS_TRIM_KEEP_ZERO_EN to forward excess beats with tkeep=0 instead of dropping them.
module axis_pkt_len_trim
  import axis_trim_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int DSIZE      = 32,
  parameter int KSIZE      = DSIZE / 8,
  parameter int USIZE      = 1,
  parameter int SKID_DEPTH = 2
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cfg_max_beats,
  axi_stream_inf.slaver    axis_in,
  axi_stream_inf.master    axis_out,
  output logic             trim_pulse,
  output logic [CNT_W-1:0] trim_cnt
);
`ifdef AXIS_TRIM_KEEP_ZERO_EN
  localparam bit KEEP_ZERO = 1'b1;
`else
  localparam bit KEEP_ZERO = 1'b0;
`endif
  localparam int W = USIZE + KSIZE + 1 + DSIZE;
  trim_state_e      state, state_n;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_n, lim, lim_n;
  logic             sk_ready, accept, push, hit, last;
  logic [KSIZE-1:0] keep;
  logic [W-1:0]     src_data, dst_data;
  logic             dst_valid;
  assign axis_in.axis_tready = sk_ready || (!KEEP_ZERO && state == S_DISCARD);
  assign accept = axis_in.axis_tvalid && axis_in.axis_tready;
  always_comb begin
    state_n    = state;
    beat_cnt_n = beat_cnt;
    lim_n      = lim;
    hit        = 1'b0;
    if (accept) begin
      case (state)
        S_IDLE: begin
          lim_n      = cfg_max_beats;
          beat_cnt_n = CNT_W'(1);
          hit        = !axis_in.axis_tlast && cfg_max_beats == CNT_W'(1);
          state_n    = axis_in.axis_tlast ? S_IDLE : hit ? S_DISCARD : S_PASS;
        end
        S_PASS: begin
          beat_cnt_n = beat_cnt + CNT_W'(1);
          hit        = !axis_in.axis_tlast && lim != '0 && beat_cnt_n == lim;
          state_n    = axis_in.axis_tlast ? S_IDLE : hit ? S_DISCARD : S_PASS;
        end
        default: state_n = axis_in.axis_tlast ? S_IDLE : S_DISCARD;
      endcase
    end
  end
  // Drop mode swallows excess beats and closes the packet on the limit beat;
  // keep-zero mode forwards everything and only blanks tkeep past the limit.
  always_comb begin
    push     = accept && (KEEP_ZERO || state != S_DISCARD);
    last     = axis_in.axis_tlast || (!KEEP_ZERO && hit);
    keep     = (KEEP_ZERO && state == S_DISCARD) ? '0 : axis_in.axis_tkeep;
    src_data = {axis_in.axis_tuser, keep, last, axis_in.axis_tdata};
  end
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      beat_cnt   <= '0;
      lim        <= '0;
      trim_pulse <= 1'b0;
      trim_cnt   <= '0;
    end else begin
      state      <= state_n;
      beat_cnt   <= beat_cnt_n;
      lim        <= lim_n;
      trim_pulse <= hit;
      if (hit && trim_cnt != '1) trim_cnt <= trim_cnt + CNT_W'(1);
    end
  end
  axis_trim_skid_buf #(.W(W), .SKID_DEPTH(SKID_DEPTH)) u_skid (
    .clock     (clock),
    .rst_n     (rst_n),
    .src_data  (src_data),
    .src_valid (push),
    .src_ready (sk_ready),
    .dst_data  (dst_data),
    .dst_valid (dst_valid),
    .dst_ready (axis_out.axis_tready)
  );
  assign axis_out.axis_tvalid = dst_valid;
  assign axis_out.axis_tdata  = dst_data[DSIZE-1:0];
  assign axis_out.axis_tlast  = dst_data[DSIZE];
  assign axis_out.axis_tkeep  = dst_data[DSIZE+1 +: KSIZE];
  assign axis_out.axis_tuser  = dst_data[DSIZE+1+KSIZE +: USIZE];
endmodule
